// File: rtl/multi_cycle_control.sv
// Multi-cycle RISC-V style control FSM: IF/ID/EX/MEM/WB sequencing with a saturating cycle counter.
// Define MCC_ECALL_HALT_EN to let ECALL with rf17==ECALL_CODE park the FSM in HALT until reset.
module multi_cycle_control #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ECALL_CODE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [XLEN-1:0]  rf17,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             is_halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_FUNC = 2'b10;

`ifdef MCC_ECALL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_count_q;

  logic       pcw_c, pcs_c, iod_c, mrd_c, mwr_c, irw_c;
  logic       m2r_c, rgw_c, p2r_c, asa_c, hlt_c;
  logic [1:0] asb_c, aop_c;
  logic       ecall_hit;

  assign ecall_hit = (opcode == OP_ECALL) && (rf17 == XLEN'(ECALL_CODE));

  always_comb begin
    state_d = state_q;
    pcw_c   = 1'b0;
    pcs_c   = 1'b0;
    iod_c   = 1'b0;
    mrd_c   = 1'b0;
    mwr_c   = 1'b0;
    irw_c   = 1'b0;
    m2r_c   = 1'b0;
    rgw_c   = 1'b0;
    p2r_c   = 1'b0;
    asa_c   = 1'b0;
    hlt_c   = 1'b0;
    asb_c   = SRCB_RS2;
    aop_c   = ALU_ADD;

    case (state_q)
      S_IF: begin
        mrd_c = 1'b1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          state_d = S_ID;
        end
      end

      S_ID: begin
        case (opcode)
          OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
          default: begin
            if (HALT_EN && ecall_hit) begin
              state_d = S_HALT;
            end else begin
              pcw_c   = 1'b1;
              pcs_c   = 1'b1;
              state_d = S_IF;
            end
          end
        endcase
      end

      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            asa_c   = 1'b1;
            asb_c   = SRCB_RS2;
            aop_c   = ALU_FUNC;
            state_d = S_WB;
          end
          OP_ARITH_IMM: begin
            asa_c   = 1'b1;
            asb_c   = SRCB_IMM;
            aop_c   = ALU_FUNC;
            state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            asa_c   = 1'b1;
            asb_c   = SRCB_IMM;
            aop_c   = ALU_ADD;
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            asb_c   = SRCB_IMM;
            aop_c   = ALU_ADD;
            pcw_c   = 1'b1;
            pcs_c   = ~branch_taken;
            state_d = S_IF;
          end
          OP_JAL, OP_JALR: begin
            // JAL adds the offset to pc, JALR to rs1; both link pc+4
            asa_c   = (opcode == OP_JALR);
            asb_c   = SRCB_IMM;
            aop_c   = ALU_ADD;
            pcw_c   = 1'b1;
            rgw_c   = 1'b1;
            p2r_c   = 1'b1;
            state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        iod_c = 1'b1;
        if (opcode == OP_LOAD) begin
          mrd_c = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else if (opcode == OP_STORE) begin
          mwr_c = 1'b1;
          if (mem_ready) begin
            pcw_c   = 1'b1;
            pcs_c   = 1'b1;
            state_d = S_IF;
          end
        end else begin
          state_d = S_IF;
        end
      end

      S_WB: begin
        rgw_c   = 1'b1;
        m2r_c   = (opcode == OP_LOAD);
        pcw_c   = 1'b1;
        pcs_c   = 1'b1;
        state_d = S_IF;
      end

      S_HALT: begin
        if (HALT_EN) hlt_c = 1'b1;
        else         state_d = S_IF;
      end

      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IF;
      cycle_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_HALT && cycle_count_q != '1)
        cycle_count_q <= cycle_count_q + CNT_W'(1);
    end
  end

  // Gate every control with reset so an asserted reset silences outputs without waiting for clk
  assign pc_write    = reset & pcw_c;
  assign pc_source   = reset & pcs_c;
  assign i_or_d      = reset & iod_c;
  assign mem_read    = reset & mrd_c;
  assign mem_write   = reset & mwr_c;
  assign ir_write    = reset & irw_c;
  assign mem_to_reg  = reset & m2r_c;
  assign reg_write   = reset & rgw_c;
  assign pc_to_reg   = reset & p2r_c;
  assign alu_src_a   = reset & asa_c;
  assign alu_src_b   = reset ? asb_c : '0;
  assign alu_op      = reset ? aop_c : '0;
  assign is_halted   = reset & hlt_c;
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: stimulus queues per-cycle expectations, a monitor compares them.
// Expectations for the ECALL case follow MCC_ECALL_HALT_EN when it is defined.
module tb_multi_cycle_control;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;
  localparam logic [6:0] OP_BAD       = 7'b1111111;

  // {pcw,pcs,iod,mrd,mwr,irw,m2r,rgw,p2r,asa,asb[1:0],aop[1:0],hlt}
  function automatic logic [14:0] mk(input bit pcw, input bit pcs, input bit iod, input bit mrd,
                                     input bit mwr, input bit irw, input bit m2r, input bit rgw,
                                     input bit p2r, input bit asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input bit hlt);
    return {pcw, pcs, iod, mrd, mwr, irw, m2r, rgw, p2r, asa, asb, aop, hlt};
  endfunction

  localparam logic [14:0] E_ZERO    = 15'd0;
  localparam logic [14:0] E_IF_WAIT = mk(0,0,0,1,0,0,0,0,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_IF_GO   = mk(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_ID_NOP  = mk(1,1,0,0,0,0,0,0,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_EX_R    = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0);
  localparam logic [14:0] E_EX_I    = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b10,0);
  localparam logic [14:0] E_EX_LS   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0);
  localparam logic [14:0] E_EX_BT   = mk(1,0,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
  localparam logic [14:0] E_EX_BN   = mk(1,1,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
  localparam logic [14:0] E_EX_JAL  = mk(1,0,0,0,0,0,0,1,1,0,2'b10,2'b00,0);
  localparam logic [14:0] E_EX_JALR = mk(1,0,0,0,0,0,0,1,1,1,2'b10,2'b00,0);
  localparam logic [14:0] E_MEM_LD  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_MEM_ST  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_MEM_STD = mk(1,1,1,0,1,0,0,0,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_WB_R    = mk(1,1,0,0,0,0,0,1,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_WB_LD   = mk(1,1,0,0,0,0,1,1,0,0,2'b00,2'b00,0);
  localparam logic [14:0] E_HALT    = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,1);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reset_s = 1'b0;
  logic [6:0]  opcode = '0;
  logic [31:0] rf17 = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;

  logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_write, pc_to_reg, alu_src_a, is_halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  logic        s_pcw, s_pcs, s_iod, s_mrd, s_mwr, s_irw, s_m2r, s_rgw, s_p2r, s_asa, s_hlt;
  logic [1:0]  s_asb, s_aop;
  logic [2:0]  s_state;
  logic [3:0]  s_count;

  always #5 clk = ~clk;

  multi_cycle_control #(.XLEN(32), .CNT_W(32), .ECALL_CODE(10)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rf17(rf17), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .is_halted(is_halted), .cycle_count(cycle_count)
  );

  multi_cycle_control #(.XLEN(32), .CNT_W(4), .ECALL_CODE(10)) dut_small (
    .clk(clk), .reset(reset_s), .opcode(OP_ARITH), .rf17(32'd0), .mem_ready(1'b1),
    .branch_taken(1'b0), .pc_write(s_pcw), .pc_source(s_pcs), .i_or_d(s_iod),
    .mem_read(s_mrd), .mem_write(s_mwr), .ir_write(s_irw), .mem_to_reg(s_m2r),
    .reg_write(s_rgw), .pc_to_reg(s_p2r), .alu_src_a(s_asa), .alu_src_b(s_asb),
    .alu_op(s_aop), .state(s_state), .is_halted(s_hlt), .cycle_count(s_count)
  );

  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic [14:0] ctl;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n4      = 0;
  bit   s_on    = 1'b0;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  // Monitor: samples away from the rising edge, on each falling clk edge or reset assertion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "state", 32'(state), 32'(e.st));
        chk(e.nm, "ctl", 32'({pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                              mem_to_reg, reg_write, pc_to_reg, alu_src_a, alu_src_b,
                              alu_op, is_halted}), 32'(e.ctl));
        chk(e.nm, "cycle_count", cycle_count, e.cnt);
        chk(e.nm, "cnt4", 32'(s_count), 32'(e.cnt4));
      end
    end
  end

  task automatic step(input string nm, input logic rs, input logic [6:0] opc, input logic mr,
                      input logic bt, input logic [31:0] rf, input logic [2:0] es,
                      input logic [14:0] ec, input logic [31:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; reset_s = s_on;
    opcode = opc; mem_ready = mr; branch_taken = bt; rf17 = rf;
    e.nm = nm; e.st = es; e.ctl = ec; e.cnt = ecnt;
    if (s_on) begin
      e.cnt4 = sat4(n4);
      n4++;
    end else begin
      e.cnt4 = '0;
    end
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    step("rst", 0, OP_ARITH, 1, 0, 0, 3'd0, E_ZERO, 0);
    s_on = 1'b1;
    // ARITHMETIC, mem_ready always high
    step("ar_if",  1, OP_ARITH, 1, 0, 0, 3'd0, E_IF_GO, 0);
    step("ar_id",  1, OP_ARITH, 1, 0, 0, 3'd1, E_ZERO,  1);
    step("ar_ex",  1, OP_ARITH, 1, 0, 0, 3'd2, E_EX_R,  2);
    step("ar_wb",  1, OP_ARITH, 1, 0, 0, 3'd4, E_WB_R,  3);
    // LOAD: 3 stalled IF cycles, 2 stalled MEM cycles
    step("ld_if0", 1, OP_LOAD, 0, 0, 0, 3'd0, E_IF_WAIT, 4);
    step("ld_if1", 1, OP_LOAD, 0, 0, 0, 3'd0, E_IF_WAIT, 5);
    step("ld_if2", 1, OP_LOAD, 0, 0, 0, 3'd0, E_IF_WAIT, 6);
    step("ld_if3", 1, OP_LOAD, 1, 0, 0, 3'd0, E_IF_GO,   7);
    step("ld_id",  1, OP_LOAD, 0, 0, 0, 3'd1, E_ZERO,    8);
    step("ld_ex",  1, OP_LOAD, 0, 0, 0, 3'd2, E_EX_LS,   9);
    step("ld_m0",  1, OP_LOAD, 0, 0, 0, 3'd3, E_MEM_LD,  10);
    step("ld_m1",  1, OP_LOAD, 0, 0, 0, 3'd3, E_MEM_LD,  11);
    step("ld_m2",  1, OP_LOAD, 1, 0, 0, 3'd3, E_MEM_LD,  12);
    step("ld_wb",  1, OP_LOAD, 1, 0, 0, 3'd4, E_WB_LD,   13);
    // BRANCH taken then not taken
    step("bt_if",  1, OP_BRANCH, 1, 1, 0, 3'd0, E_IF_GO, 14);
    step("bt_id",  1, OP_BRANCH, 1, 1, 0, 3'd1, E_ZERO,  15);
    step("bt_ex",  1, OP_BRANCH, 1, 1, 0, 3'd2, E_EX_BT, 16);
    step("bn_if",  1, OP_BRANCH, 1, 0, 0, 3'd0, E_IF_GO, 17);
    step("bn_id",  1, OP_BRANCH, 1, 0, 0, 3'd1, E_ZERO,  18);
    step("bn_ex",  1, OP_BRANCH, 1, 0, 0, 3'd2, E_EX_BN, 19);
    // ARITHMETIC_IMM, JAL, JALR, unknown opcode
    step("ai_if",  1, OP_ARITH_IMM, 1, 0, 0, 3'd0, E_IF_GO, 20);
    step("ai_id",  1, OP_ARITH_IMM, 1, 0, 0, 3'd1, E_ZERO,  21);
    step("ai_ex",  1, OP_ARITH_IMM, 1, 0, 0, 3'd2, E_EX_I,  22);
    step("ai_wb",  1, OP_ARITH_IMM, 1, 0, 0, 3'd4, E_WB_R,  23);
    step("jal_if", 1, OP_JAL,  1, 0, 0, 3'd0, E_IF_GO,   24);
    step("jal_id", 1, OP_JAL,  1, 0, 0, 3'd1, E_ZERO,    25);
    step("jal_ex", 1, OP_JAL,  1, 0, 0, 3'd2, E_EX_JAL,  26);
    step("jr_if",  1, OP_JALR, 1, 0, 0, 3'd0, E_IF_GO,   27);
    step("jr_id",  1, OP_JALR, 1, 0, 0, 3'd1, E_ZERO,    28);
    step("jr_ex",  1, OP_JALR, 1, 0, 0, 3'd2, E_EX_JALR, 29);
    step("bad_if", 1, OP_BAD,  1, 0, 0, 3'd0, E_IF_GO,   30);
    step("bad_id", 1, OP_BAD,  1, 0, 0, 3'd1, E_ID_NOP,  31);
    // STORE completing, then a STORE cut short by reset
    step("st_if",  1, OP_STORE, 1, 0, 0, 3'd0, E_IF_GO,   32);
    step("st_id",  1, OP_STORE, 1, 0, 0, 3'd1, E_ZERO,    33);
    step("st_ex",  1, OP_STORE, 1, 0, 0, 3'd2, E_EX_LS,   34);
    step("st_m0",  1, OP_STORE, 0, 0, 0, 3'd3, E_MEM_ST,  35);
    step("st_m1",  1, OP_STORE, 1, 0, 0, 3'd3, E_MEM_STD, 36);
    step("sr_if",  1, OP_STORE, 1, 0, 0, 3'd0, E_IF_GO,   37);
    step("sr_id",  1, OP_STORE, 1, 0, 0, 3'd1, E_ZERO,    38);
    step("sr_ex",  1, OP_STORE, 1, 0, 0, 3'd2, E_EX_LS,   39);
    step("sr_m0",  1, OP_STORE, 0, 0, 0, 3'd3, E_MEM_ST,  40);
    #6;
    e.nm = "async_rst"; e.st = 3'd0; e.ctl = E_ZERO; e.cnt = 0; e.cnt4 = sat4(n4 - 1);
    sb.push_back(e);
    reset = 1'b0;
    step("rst_hold", 0, OP_ECALL, 1, 0, 5, 3'd0, E_ZERO, 0);
    // ECALL with a non-matching rf17 is always a no-op
    step("ec5_if", 1, OP_ECALL, 1, 0, 5,  3'd0, E_IF_GO,  0);
    step("ec5_id", 1, OP_ECALL, 1, 0, 5,  3'd1, E_ID_NOP, 1);
    step("ec_if",  1, OP_ECALL, 1, 0, 10, 3'd0, E_IF_GO,  2);
`ifdef MCC_ECALL_HALT_EN
    step("ec_id",  1, OP_ECALL, 1, 0, 10, 3'd1, E_ZERO, 3);
    step("halt0",  1, OP_ECALL, 1, 0, 10, 3'd5, E_HALT, 4);
    step("halt1",  1, OP_ECALL, 1, 0, 10, 3'd5, E_HALT, 4);
    step("halt2",  1, OP_ECALL, 1, 0, 10, 3'd5, E_HALT, 4);
`else
    step("ec_id",  1, OP_ECALL, 1, 0, 10, 3'd1, E_ID_NOP, 3);
    step("ec_if2", 1, OP_ECALL, 1, 0, 10, 3'd0, E_IF_GO,  4);
    step("ec_id2", 1, OP_ECALL, 1, 0, 10, 3'd1, E_ID_NOP, 5);
    step("ec_if3", 1, OP_ECALL, 1, 0, 10, 3'd0, E_IF_GO,  6);
`endif
    repeat (3) @(posedge clk);
    chk("scoreboard", "pending", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
